// File: rtl/nibble_serial_pkg.sv
// Shared types and helpers for the nibble-serial adder/subtractor.
package nibble_serial_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the nibble index counter; never narrower than one bit.
    function automatic int idx_width(input int nibbles);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << i) < nibbles) begin
                w = i + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/nibble_serial_adder_rca.sv
// Four-bit ripple-carry adder, the single arithmetic slice reused for every nibble.
module four_bit_rca
    import nibble_serial_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] sum,
    output logic                cout
);

    logic [NIBBLE_W:0] c;

    assign c[0] = cin;

    // Plain full-adder chain so the carry path stays a true ripple.
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign sum[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Wide adder/subtractor that reuses one 4-bit RCA over all nibbles, LSB first.
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | ready=1, waiting for start; operands captured on accept
//   RUN   | one nibble per clock through the RCA, idx = current nibble
//   DONE  | done=1 for one cycle, results already registered
//
module nibble_serial_adder
    import nibble_serial_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          sub,
    input  logic [NIBBLE_W*NIBBLES-1:0]   A,
    input  logic [NIBBLE_W*NIBBLES-1:0]   B,
    output logic                          ready,
    output logic                          done,
    output logic [NIBBLE_W*NIBBLES-1:0]   S,
    output logic                          Cout,
    output logic                          Ovf
);

    localparam int             IW       = idx_width(NIBBLES);
    localparam logic [IW-1:0]  LAST_IDX = IW'(NIBBLES - 1);

    state_t                             state;
    logic [IW-1:0]                      idx;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   a_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   b_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   w_q;
    logic [NIBBLES-1:0][NIBBLE_W-1:0]   w_next;
    logic                               carry_q;

    logic [NIBBLE_W-1:0]                rca_a;
    logic [NIBBLE_W-1:0]                rca_b;
    logic [NIBBLE_W-1:0]                rca_sum;
    logic                               rca_cout;

    logic                               a_msb;
    logic                               b_eff_msb;

    // Operand nibble select; a compare-based mux keeps unused idx codes harmless.
    always_comb begin
        rca_a = '0;
        rca_b = '0;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                rca_a = a_q[i];
                rca_b = b_q[i];
            end
        end
    end

    four_bit_rca u_rca (
        .a    (rca_a),
        .b    (rca_b),
        .cin  (carry_q),
        .sum  (rca_sum),
        .cout (rca_cout)
    );

    // Work word with the current nibble merged in, so the last cycle can publish it directly.
    always_comb begin
        w_next = w_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (idx == IW'(i)) begin
                w_next[i] = rca_sum;
            end
        end
    end

    // b_q already holds the inverted operand for subtract, so its MSB is b_eff's MSB.
    assign a_msb     = a_q[NIBBLES-1][NIBBLE_W-1];
    assign b_eff_msb = b_q[NIBBLES-1][NIBBLE_W-1];

    // Sequencer: capture, per-nibble accumulate, and publish results on the final nibble.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            w_q     <= '0;
            carry_q <= 1'b0;
            ready   <= 1'b1;
            done    <= 1'b0;
            S       <= '0;
            Cout    <= 1'b0;
            Ovf     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_q     <= A;
                        b_q     <= sub ? ~B : B;
                        carry_q <= sub;
                        idx     <= '0;
                        ready   <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    w_q     <= w_next;
                    carry_q <= rca_cout;
                    if (idx == LAST_IDX) begin
                        S     <= w_next;
                        Cout  <= rca_cout;
                        Ovf   <= (a_msb == b_eff_msb) && (rca_sum[NIBBLE_W-1] != a_msb);
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    idx   <= '0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    idx   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench for nibble_serial_adder (default 4 nibbles, 16-bit operands).
module tb_nibble_serial_adder;

    localparam int N = 4;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic         sub;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         ready;
    logic         done;
    logic [W-1:0] S;
    logic         Cout;
    logic         Ovf;

    typedef struct packed {
        logic [W-1:0] s;
        logic         cout;
        logic         ovf;
    } exp_t;

    exp_t         sb[$];
    int           n_tests = 0;
    int           n_fail  = 0;
    logic [W-1:0] last_s;
    logic         last_cout;
    logic         last_ovf;

    always #5 clk = ~clk;

    nibble_serial_adder #(.NIBBLES(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .sub   (sub),
        .A     (A),
        .B     (B),
        .ready (ready),
        .done  (done),
        .S     (S),
        .Cout  (Cout),
        .Ovf   (Ovf)
    );

    // Reference: full-width arithmetic, independent of the nibble sequencing.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s_);
        logic [W-1:0] be;
        logic [W:0]   full;
        exp_t         e;
        be     = s_ ? ~b : b;
        full   = {1'b0, a} + {1'b0, be} + {{W{1'b0}}, s_};
        e.s    = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (a[W-1] == be[W-1]) && (full[W-1] != a[W-1]);
        return e;
    endfunction

    // Starts at a negedge, leaves at the negedge after the op's last edge (k+N+1).
    // poke: cycle c at which a stray start (A=AAAA) is sampled on edge k+c; 0 = none.
    task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic s_, input exp_t want, input int poke);
        exp_t got;
        int   pulses;
        n_tests++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready_before_accept: got %b want 1", name, ready);
        end
        sb.push_back(want);
        A = a; B = b; sub = s_; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        A = W'($urandom); B = W'($urandom); sub = 1'($urandom_range(0, 1));
        n_tests++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s after_accept: ready=%b done=%b want 0 0", name, ready, done);
        end
        pulses = 0;
        for (int c = 1; c <= N + 1; c++) begin
            if (c == poke) begin
                start = 1'b1; A = 16'hAAAA; B = 16'h5555;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (done === 1'b1) pulses++;
            n_tests++;
            if (done !== (c == N) || ready !== (c == N + 1)) begin
                n_fail++;
                $display("FAIL %s handshake c=%0d: done=%b ready=%b want %b %b",
                         name, c, done, ready, (c == N), (c == N + 1));
            end
            if (c < N) begin
                n_tests++;
                if (S !== last_s || Cout !== last_cout || Ovf !== last_ovf) begin
                    n_fail++;
                    $display("FAIL %s held c=%0d: S=%h C=%b V=%b want %h %b %b",
                             name, c, S, Cout, Ovf, last_s, last_cout, last_ovf);
                end
            end
            if (c == N) begin
                n_tests++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL %s scoreboard: got empty want entry", name);
                end else begin
                    got = sb.pop_front();
                    if (S !== got.s || Cout !== got.cout || Ovf !== got.ovf) begin
                        n_fail++;
                        $display("FAIL %s result: S=%h C=%b V=%b want %h %b %b",
                                 name, S, Cout, Ovf, got.s, got.cout, got.ovf);
                    end
                    last_s = got.s; last_cout = got.cout; last_ovf = got.ovf;
                end
            end
        end
        start = 1'b0;
        n_tests++;
        if (pulses != 1) begin
            n_fail++;
            $display("FAIL %s done_pulses: got %0d want 1", name, pulses);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; sub = 1'b0; A = '0; B = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b1 || done !== 1'b0 || S !== 16'h0000 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset: ready=%b done=%b S=%h C=%b V=%b want 1 0 0000 0 0",
                     ready, done, S, Cout, Ovf);
        end
        last_s = '0; last_cout = 1'b0; last_ovf = 1'b0;
    endtask

    task automatic test_add();
        exp_t e;
        e = '{s: 16'h5555, cout: 1'b0, ovf: 1'b0};
        run_op("add", 16'h1234, 16'h4321, 1'b0, e, 0);
    endtask

    task automatic test_carry_chain();
        exp_t e;
        e = '{s: 16'h0000, cout: 1'b1, ovf: 1'b0};
        run_op("carry_wrap", 16'hFFFF, 16'h0001, 1'b0, e, 0);
        e = '{s: 16'h8000, cout: 1'b0, ovf: 1'b1};
        run_op("carry_ovf", 16'h7FFF, 16'h0001, 1'b0, e, 0);
    endtask

    task automatic test_subtract();
        exp_t e;
        e = '{s: 16'hFFFE, cout: 1'b0, ovf: 1'b0};
        run_op("sub_borrow", 16'h0005, 16'h0007, 1'b1, e, 0);
        e = '{s: 16'h7FFF, cout: 1'b1, ovf: 1'b1};
        run_op("sub_ovf", 16'h8000, 16'h0001, 1'b1, e, 0);
    endtask

    task automatic test_busy_start();
        exp_t e;
        e = '{s: 16'h0002, cout: 1'b0, ovf: 1'b0};
        run_op("busy_run", 16'h0001, 16'h0001, 1'b0, e, 2);
        e = '{s: 16'h0003, cout: 1'b0, ovf: 1'b0};
        run_op("busy_last", 16'h0001, 16'h0002, 1'b0, e, N);
        e = '{s: 16'h0004, cout: 1'b0, ovf: 1'b0};
        run_op("busy_done", 16'h0001, 16'h0003, 1'b0, e, N + 1);
    endtask

    task automatic test_reset_mid_op();
        exp_t e;
        A = 16'h1111; B = 16'h1111; sub = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        n_tests++;
        if (ready !== 1'b1 || done !== 1'b0 || S !== 16'h0000 || Cout !== 1'b0 || Ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_reset: ready=%b done=%b S=%h C=%b V=%b want 1 0 0000 0 0",
                     ready, done, S, Cout, Ovf);
        end
        repeat (2) begin
            @(negedge clk);
            n_tests++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done: got %b want 0", done);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if (ready !== 1'b1 || done !== 1'b0 || S !== 16'h0000) begin
            n_fail++;
            $display("FAIL abort_release: ready=%b done=%b S=%h want 1 0 0000", ready, done, S);
        end
        last_s = '0; last_cout = 1'b0; last_ovf = 1'b0;
        e = '{s: 16'h1010, cout: 1'b0, ovf: 1'b0};
        run_op("after_abort", 16'h0F0F, 16'h0101, 1'b0, e, 0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s_;
        for (int i = 0; i < 12; i++) begin
            a  = W'($urandom);
            b  = W'($urandom);
            s_ = 1'($urandom_range(0, 1));
            run_op("b2b", a, b, s_, model(a, b, s_), (i % 3 == 0) ? 1 : 0);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_subtract();
        test_busy_start();
        test_reset_mid_op();
        test_back_to_back();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
